round_off: RTL and testbench
============================

Name: round_off

Overview:
- Rounding stage of the posit (N=32, ES=3) arithmetic datapath.
- Takes a 64-bit normalised mantissa (hidden bit at bit 63) plus the regime k, exponent and sign produced upstream.
- Rounds the fraction round-to-nearest-even (RNE) to the number of fraction bits the 32-bit posit has room for.
- Propagates any rounding carry into exponent, then regime; presents the result with a start/done handshake to the encode stage.

Parameters:
None. N=32 and ES=3 are fixed package constants, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- shifted_mantissa  in  64  [63]=hidden bit, [62:0]=fraction, MSB-aligned
- k_out  in  6  signed regime value k, two's complement, -32..31
- exp_out  in  3  exponent field
- sign_out  in  1  sign
- mantissa_out  out  32  rounded significand
- k_final  out  6  signed regime after carry
- exp_final  out  3  exponent after carry
- sign_final  out  1  sign passthrough
- done  out  1  result-valid pulse

Behaviour:
- One clock domain. Reset is synchronous, active-low.
- On reset: state=IDLE; all outputs 0, including done.
- FSM states: IDLE, ROUND, COMPLETE.
  - IDLE: when start=1, latch all inputs, then go to ROUND. Otherwise stay in IDLE.
  - ROUND: compute the result, register all outputs, go to COMPLETE.
  - COMPLETE: done=1 for exactly this one cycle, then go to IDLE.
- Latency: start sampled at edge E0; outputs update and done rises at E0+2; done falls at E0+3.
- start outside IDLE is ignored. Held start re-triggers from IDLE.
- Outputs hold their values until the next ROUND or reset.
- Regime length rl: if k>=0, rl=k+2; if k<0, rl=1-k.
- Fraction bits fb = 31-rl-ES.
- Pass-through case, fb<0 (k>=27 or k<=-28):
  - mantissa_out={sm[63],31'b0}.
  - exp and k pass unchanged; no rounding. Saturation is handled downstream.
- Rounding case, 0<=fb<=26:
  - Kept fraction F = sm[62:63-fb] (empty when fb=0).
  - Guard g = sm[62-fb]; sticky s = OR(sm[61-fb:0]).
  - LSB L = sm[63-fb]. When fb=0, L = LSB of exp_out.
  - Round up iff g & (s | L).
- Increment is applied to {hidden,F}:
  - No carry out of the hidden bit: mantissa_out[31]=hidden, [30:31-fb]=F', remaining bits 0.
  - Carry out (hidden and F all ones): mantissa_out=0x8000_0000 and exp_final=exp+1.
  - If exp was 7: exp_final=0 and k_final=k+1. This cannot overflow because k<=26 in the rounding case.
- fb=0 with round up: mantissa_out=0x8000_0000 and the increment goes to exp/k as above.
- sm=0: mantissa_out=0; exp, k and sign pass through.
- sign_final=latched sign_out always.
- Reset asserted mid-operation: return to IDLE the next edge, outputs cleared, no done.

Decomposition:
- Package round_pkg holds:
  - N=32, ES=3
  - the state enum {IDLE, ROUND, COMPLETE}
  - a function regime_len(k) returning 0..33
- One natural combinational sub-module, rne_round_core. It takes sm, k and exp and returns mantissa, k and exp.
- round_off wraps rne_round_core with the FSM and the input/output registers.

Test Plan:
1. sm=0xFFFF_FFFF_FFFF_FFFF, k=2, exp=0 -> rl=4, fb=24, carry: mantissa_out=0x8000_0000, exp_final=1, k_final=2, done one cycle at E0+2.
2. Same sm, k=2, exp=7 -> mantissa_out=0x8000_0000, exp_final=0, k_final=3.
3. Ties with k=0, exp=0 (fb=26):
   - sm=0x8000_0010_0000_0000 (exact tie, L=0) -> mantissa_out=0x8000_0000.
   - sm=0x8000_0030_0000_0000 (tie, L=1) -> mantissa_out=0x8000_0040.
4. sm=0x8000_0000_0000_0001, k=25, exp=7 -> fb=1, no round: mantissa_out=0x8000_0000, exp_final=7, k_final=25.
   - sm=0, k=4 -> mantissa_out=0, k_final=4.
5. sm=0xFFFF_FFFF_0000_0000, k=-31, exp=2 -> pass-through: mantissa_out=0x8000_0000, k_final=6'h21, exp_final=2.
6. Handshake:
   - start pulsed during ROUND and COMPLETE -> ignored, single done.
   - rst_n=0 during ROUND -> no done, outputs 0.
   - 23 back-to-back requests each produce exactly one done.

Source files
------------

// File: rtl/round_pkg.sv
// Shared constants, FSM state type and helpers for the posit(32,3) rounding stage.
//   N, ES       : fixed posit width and exponent-field size
//   state_e     : handshake FSM states
//   regime_len  : regime field length (terminating bit included) for a regime value k
package round_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned ES = 3;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        COMPLETE
    } state_e;

    // k >= 0 -> k+2, k < 0 -> 1-k. Returns 0..33 for k in -32..31; the modulo-64
    // arithmetic below yields the right value across the whole range.
    function automatic logic [5:0] regime_len(input logic signed [5:0] k);
        if (k >= 0) begin
            return $unsigned(k) + 6'd2;
        end
        return 6'd1 - $unsigned(k);
    endfunction

endpackage

// File: rtl/rne_round_core.sv
// Combinational round-to-nearest-even of a normalised 64-bit mantissa to the
// fraction width left over after the regime and exponent fields of a posit(32,3).
//   sm       : [63] hidden bit, [62:0] fraction, MSB-aligned
//   k_in     : signed regime value
//   exp_in   : exponent field
//   mantissa : rounded significand, hidden bit at [31], fraction MSB-aligned below it
//   k_res    : regime after a possible rounding carry
//   exp_res  : exponent after a possible rounding carry
module rne_round_core
    import round_pkg::*;
(
    input  logic        [63:0] sm,
    input  logic signed [5:0]  k_in,
    input  logic        [2:0]  exp_in,
    output logic        [31:0] mantissa,
    output logic signed [5:0]  k_res,
    output logic        [2:0]  exp_res
);

    logic        [5:0]  rl;
    logic signed [6:0]  fb;
    logic        [5:0]  fb_u;
    logic        [63:0] kept;
    logic        [63:0] sticky_mask;
    logic        [63:0] sum;
    logic               guard;
    logic               sticky;
    logic               lsb;
    logic               round_up;
    logic               carry;

    always_comb begin
        rl   = regime_len(k_in);
        fb   = 7'sd28 - $signed({1'b0, rl});  // N-1-ES-rl
        fb_u = fb[5:0];

        // {hidden, F} right-aligned; only meaningful when fb >= 0.
        kept        = sm >> (6'd63 - fb_u);
        guard       = sm[6'd62 - fb_u];
        sticky_mask = (64'd1 << (6'd62 - fb_u)) - 64'd1;
        sticky      = |(sm & sticky_mask);
        // With no fraction bits left, the exponent LSB is the last kept bit.
        lsb         = (fb_u == 6'd0) ? exp_in[0] : sm[6'd63 - fb_u];
        round_up    = guard & (sticky | lsb);
        sum         = kept + {63'd0, round_up};
        // fb == 0: the increment lands in the exponent directly.
        carry       = round_up & ((fb_u == 6'd0) | sum[fb_u + 6'd1]);

        mantissa = '0;
        k_res    = k_in;
        exp_res  = exp_in;

        if (fb < 0) begin
            // No room for fraction bits; saturation is handled downstream.
            mantissa = {sm[63], 31'd0};
        end else if (carry) begin
            mantissa = 32'h8000_0000;
            if (exp_in == 3'd7) begin
                exp_res = 3'd0;
                k_res   = k_in + 6'sd1;  // k <= 26 here, cannot overflow
            end else begin
                exp_res = exp_in + 3'd1;
            end
        end else begin
            mantissa = sum[31:0] << (6'd31 - fb_u);
        end
    end

endmodule

// File: rtl/round_off.sv
// Rounding stage of the posit(32,3) datapath with a start/done handshake.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : request, sampled only in IDLE
//   shifted_mantissa  : normalised mantissa, hidden bit at [63]
//   k_out, exp_out    : regime value and exponent from upstream
//   sign_out          : sign from upstream
//   mantissa_out      : rounded significand
//   k_final, exp_final: regime/exponent after rounding carry
//   sign_final        : latched sign
//   done              : one-cycle result-valid pulse, two edges after start is taken
module round_off
    import round_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic        [63:0] shifted_mantissa,
    input  logic signed [5:0]  k_out,
    input  logic        [2:0]  exp_out,
    input  logic               sign_out,
    output logic        [31:0] mantissa_out,
    output logic signed [5:0]  k_final,
    output logic        [2:0]  exp_final,
    output logic               sign_final,
    output logic               done
);

    state_e             state_q, state_d;
    logic        [63:0] sm_q;
    logic signed [5:0]  k_q;
    logic        [2:0]  exp_q;
    logic               sign_q;

    logic        [31:0] core_mant;
    logic signed [5:0]  core_k;
    logic        [2:0]  core_exp;

    rne_round_core u_core (
        .sm       (sm_q),
        .k_in     (k_q),
        .exp_in   (exp_q),
        .mantissa (core_mant),
        .k_res    (core_k),
        .exp_res  (core_exp)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = ROUND;
            ROUND:    state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sm_q         <= '0;
            k_q          <= '0;
            exp_q        <= '0;
            sign_q       <= 1'b0;
            mantissa_out <= '0;
            k_final      <= '0;
            exp_final    <= '0;
            sign_final   <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == COMPLETE);
            if (state_q == IDLE && start) begin
                sm_q   <= shifted_mantissa;
                k_q    <= k_out;
                exp_q  <= exp_out;
                sign_q <= sign_out;
            end
            // The result settles during ROUND and is published together with
            // done, so both become visible on the same edge.
            if (state_q == COMPLETE) begin
                mantissa_out <= core_mant;
                k_final      <= core_k;
                exp_final    <= core_exp;
                sign_final   <= sign_q;
            end
        end
    end

endmodule

// File: tb/tb_round_off.sv
module tb_round_off;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] shifted_mantissa;
    logic [5:0]  k_out;
    logic [2:0]  exp_out;
    logic        sign_out;
    logic [31:0] mantissa_out;
    logic [5:0]  k_final;
    logic [2:0]  exp_final;
    logic        sign_final;
    logic        done;

    round_off dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .shifted_mantissa (shifted_mantissa),
        .k_out            (k_out),
        .exp_out          (exp_out),
        .sign_out         (sign_out),
        .mantissa_out     (mantissa_out),
        .k_final          (k_final),
        .exp_final        (exp_final),
        .sign_final       (sign_final),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sm;
        logic [5:0]  k;
        logic [2:0]  e;
        logic        s;
        logic [31:0] m_x;
        logic [5:0]  k_x;
        logic [2:0]  e_x;
    } vec_t;

    typedef struct {
        logic [31:0] m;
        logic [5:0]  k;
        logic [2:0]  e;
        logic        s;
    } exp_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard side: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            if (done_prev) begin
                checks++;
                errors++;
                $display("FAIL done_width: got 2+ cycles expected 1");
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done expected none");
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("mantissa_out", {32'd0, mantissa_out}, {32'd0, x.m});
                check("k_final", {58'd0, k_final}, {58'd0, x.k});
                check("exp_final", {61'd0, exp_final}, {61'd0, x.e});
                check("sign_final", {63'd0, sign_final}, {63'd0, x.s});
            end
        end
        done_prev = done;
    end

    task automatic set_inputs(input int i);
        shifted_mantissa = vecs[i].sm;
        k_out            = vecs[i].k;
        exp_out          = vecs[i].e;
        sign_out         = vecs[i].s;
    endtask

    task automatic push_exp(input int i);
        exp_t x;
        x.m = vecs[i].m_x;
        x.k = vecs[i].k_x;
        x.e = vecs[i].e_x;
        x.s = vecs[i].s;
        sb.push_back(x);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Single request with latency checks; called and returns on a negedge.
    task automatic run_one(input int i);
        set_inputs(i);
        push_exp(i);
        start = 1'b1;
        @(posedge clk);            // E0
        @(negedge clk);
        start = 1'b0;
        check("lat_e0", {63'd0, done}, 64'd0);
        @(negedge clk);            // after E0+1
        check("lat_e1", {63'd0, done}, 64'd0);
        @(negedge clk);            // after E0+2
        check("lat_e2", {63'd0, done}, 64'd1);
        @(negedge clk);            // after E0+3
        check("lat_e3", {63'd0, done}, 64'd0);
        drain("run_one");
    endtask

    initial begin
        int base;
        //          sm                      k      e     s      m_x            k_x    e_x
        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 6'h02, 3'd0, 1'b0, 32'h8000_0000, 6'h02, 3'd1};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 6'h02, 3'd7, 1'b1, 32'h8000_0000, 6'h03, 3'd0};
        vecs[2]  = '{64'h8000_0010_0000_0000, 6'h00, 3'd0, 1'b0, 32'h8000_0000, 6'h00, 3'd0};
        vecs[3]  = '{64'h8000_0030_0000_0000, 6'h00, 3'd0, 1'b0, 32'h8000_0040, 6'h00, 3'd0};
        vecs[4]  = '{64'h8000_0000_0000_0001, 6'h19, 3'd7, 1'b0, 32'h8000_0000, 6'h19, 3'd7};
        vecs[5]  = '{64'h0000_0000_0000_0000, 6'h04, 3'd5, 1'b1, 32'h0000_0000, 6'h04, 3'd5};
        vecs[6]  = '{64'hFFFF_FFFF_0000_0000, 6'h21, 3'd2, 1'b0, 32'h8000_0000, 6'h21, 3'd2};
        vecs[7]  = '{64'hC000_0000_0000_0000, 6'h1A, 3'd7, 1'b0, 32'h8000_0000, 6'h1B, 3'd0};
        vecs[8]  = '{64'hC000_0000_0000_0000, 6'h25, 3'd2, 1'b0, 32'h8000_0000, 6'h25, 3'd2};
        vecs[9]  = '{64'hC000_0000_0000_0001, 6'h25, 3'd2, 1'b1, 32'h8000_0000, 6'h25, 3'd3};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'h1B, 3'd5, 1'b0, 32'h8000_0000, 6'h1B, 3'd5};
        vecs[11] = '{64'h8000_000F_FFFF_FFFF, 6'h00, 3'd0, 1'b0, 32'h8000_0000, 6'h00, 3'd0};
        vecs[12] = '{64'h8000_0010_0000_0001, 6'h3F, 3'd4, 1'b0, 32'h8000_0020, 6'h3F, 3'd4};
        vecs[13] = '{64'hC000_0000_0000_0000, 6'h00, 3'd3, 1'b1, 32'hC000_0000, 6'h00, 3'd3};

        rst_n = 1'b0;
        start = 1'b0;
        set_inputs(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mantissa", {32'd0, mantissa_out}, 64'd0);
        check("rst_k", {58'd0, k_final}, 64'd0);
        check("rst_exp", {61'd0, exp_final}, 64'd0);
        check("rst_sign", {63'd0, sign_final}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_one(i);

        // start pulsed again during ROUND and COMPLETE must be ignored.
        base = done_count;
        set_inputs(3);
        push_exp(3);
        start = 1'b1;
        repeat (3) @(posedge clk);  // E0, E0+1 (ROUND), E0+2 (COMPLETE)
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        drain("ignore_start");
        check("ignore_start_dones", 64'(done_count - base), 64'd1);

        // Reset during ROUND: no done, outputs cleared.
        base = done_count;
        set_inputs(13);
        start = 1'b1;
        @(posedge clk);             // E0
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);             // E0+1, reset taken
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_mantissa", {32'd0, mantissa_out}, 64'd0);
        check("midrst_k", {58'd0, k_final}, 64'd0);
        check("midrst_exp", {61'd0, exp_final}, 64'd0);
        check("midrst_sign", {63'd0, sign_final}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        repeat (5) @(negedge clk);
        check("midrst_no_done", 64'(done_count - base), 64'd0);
        check("midrst_hold", {32'd0, mantissa_out}, 64'd0);

        // 23 back-to-back requests with start held; inputs change after each capture.
        base = done_count;
        set_inputs(0);
        push_exp(0);
        start = 1'b1;
        for (int i = 0; i < 23; i++) begin
            @(posedge clk);         // capture edge of request i
            @(negedge clk);
            if (i == 22) begin
                start = 1'b0;
            end else begin
                set_inputs((i + 1) % NV);
                push_exp((i + 1) % NV);
            end
            @(posedge clk);
            @(posedge clk);
        end
        repeat (4) @(negedge clk);
        drain("b2b");
        check("b2b_dones", 64'(done_count - base), 64'd23);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
